uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 57600, meaning serial bit rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 16, meaning byte buffer depth; SHALL be a power of two, 2 to 256.
REQ-004 CLK100MHZ  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 tx_data  input  8  byte to transmit.
REQ-007 tx_valid  input  1  tx_data is offered this cycle.
REQ-008 tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-009 Uart_TXD  output  1  serial line; idle high.
REQ-010 tx_busy  output  1  a frame is on the line, or the FIFO is non-empty.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-012 Bit period SHALL be DIV = CLK_FREQ/BAUD_RATE cycles, integer-truncated (1736 at defaults).
REQ-013 Frame SHALL be: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-014 Each bit SHALL hold Uart_TXD for exactly DIV cycles; a frame SHALL last exactly 10*DIV cycles.
REQ-015 Uart_TXD SHALL be driven from a register, with no combinational path from inputs.
REQ-016 Handshake: a byte SHALL be accepted when tx_valid and tx_ready are both high on a rising edge; tx_data need only be stable in that cycle.
REQ-017 tx_ready SHALL equal (fifo_count < FIFO_DEPTH), computed from the registered count.
REQ-018 A write while full SHALL be ignored, even if a pop occurs in the same cycle.
REQ-019 A simultaneous push and pop SHALL leave fifo_count unchanged; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 The FSM SHALL have the states IDLE, START, DATA, STOP, with a bit counter (0..7) and a baud counter (0..DIV-1).
REQ-021 IDLE: Uart_TXD=1; if the FIFO is non-empty, the FSM SHALL pop the head byte into the shift register and enter START at the next edge.
REQ-022 START: Uart_TXD=0 for DIV cycles, then the FSM SHALL enter DATA with the bit index at 0.
REQ-023 DATA: Uart_TXD=shift[0] for DIV cycles per bit; after bit 7 the FSM SHALL enter STOP.
REQ-024 STOP: Uart_TXD=1 for DIV cycles; at the end, if the FIFO is non-empty, the FSM SHALL pop and go directly to START (zero idle gap); otherwise it SHALL go to IDLE.
REQ-025 Latency: a byte written at edge N into an empty FIFO with the FSM in IDLE SHALL give Uart_TXD=0 after edge N+2.
REQ-026 tx_busy SHALL be low only when the state is IDLE and fifo_count is 0.

Reset
REQ-027 While reset is high, the block SHALL set Uart_TXD=1, state=IDLE, both counters=0, FIFO pointers=0, fifo_count=0, tx_busy=0, tx_ready=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame, force Uart_TXD high at the next edge, and discard all buffered bytes.
REQ-029 A write in the reset cycle SHALL be ignored.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum (IDLE, START, DATA, STOP), the frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8) and the default CLK_FREQ and BAUD_RATE.
REQ-031 The FIFO SHALL be a sub-module, uart_tx_fifo (synchronous, single clock, first-word-fall-through, with count output); the FSM, baud counter and shift register SHALL live in uart_tx.

Verification
REQ-032 Single byte: write 0xA5 at defaults -> Uart_TXD is 0 then 1,0,1,0,0,1,0,1 then 1, each held 1736 cycles; total 17360 cycles; tx_busy then falls.
REQ-033 Back-to-back: write 0x0A, 0x0D on consecutive cycles -> two frames with zero idle cycles between them, and the second start bit begins exactly 17360 cycles after the first.
REQ-034 Full FIFO: with FIFO_DEPTH=16 and Uart_TXD busy, write 17 bytes 0x00..0x10 -> tx_ready falls after the 16th write, 0x10 is dropped, and bytes 0x00..0x0F are transmitted in order.
REQ-035 Reset mid-frame: assert reset during data bit 3 of 0xFF with 3 bytes queued -> Uart_TXD=1 at the next edge, fifo_count=0, and no further frames.
REQ-036 Loopback: a bench UART receiver sampling mid-bit at 57600 baud recovers the string 0x31,0x32,0x33 with no framing errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Frame constants: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;

  // Default clocking: 100 MHz board clock, 57600 baud line
  localparam int DEFAULT_CLK_FREQ  = 100_000_000;
  localparam int DEFAULT_BAUD_RATE = 57600;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmitter: single clock, first-word-fall-through,
// with an occupancy count. The head byte is visible on rd_data whenever the
// FIFO is non-empty, so the consumer can pop and use it in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          push;
  logic          pop;

  // A write while full is dropped even if a pop happens in the same cycle,
  // so fullness is judged from the registered count only.
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage array; not reset so it can map onto RAM resources
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered 8N1 serial output with a valid/ready byte input.
// Uart_TXD is a registered decode of the FSM state and shift register, so the
// line lags the state by one cycle uniformly and every bit lasts DIV cycles.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          Uart_TXD,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  tx_state_t     state_reg;
  logic [BW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          txd_reg;

  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          baud_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK100MHZ),
    .srst    (reset),
    .wr_en   (tx_valid),
    .wr_data (tx_data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign baud_end = (baud_cnt_reg == BW'(DIV - 1));

  // Pop from IDLE as soon as data exists, or at the end of a stop bit so
  // consecutive frames follow with no idle gap.
  assign fifo_pop = !fifo_empty &&
                    ((state_reg == IDLE) || ((state_reg == STOP) && baud_end));

  assign tx_ready = !fifo_full;
  assign tx_busy  = !((state_reg == IDLE) && fifo_empty);
  assign Uart_TXD = txd_reg;

  // Frame sequencer: state, baud and bit counters, shift register and line
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      txd_reg      <= STOP_BIT;
    end else begin
      case (state_reg)
        START:   txd_reg <= START_BIT;
        DATA:    txd_reg <= shift_reg[0];
        default: txd_reg <= STOP_BIT;
      endcase

      case (state_reg)
        IDLE: begin
          baud_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
          if (!fifo_empty) begin
            shift_reg <= fifo_head;
            state_reg <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            shift_reg    <= {1'b0, shift_reg[7:1]};
            if (bit_cnt_reg == 3'(DATA_BITS - 1)) begin
              bit_cnt_reg <= '0;
              state_reg   <= STOP;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            if (!fifo_empty) begin
              shift_reg <= fifo_head;
              state_reg <= START;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          baud_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx, run with a 10-cycle bit period to keep runs short.
module tb_uart_tx;

  localparam int CLK_FREQ   = 1_000_000;
  localparam int BAUD_RATE  = 100_000;
  localparam int DIV        = 10;
  localparam int FIFO_DEPTH = 16;

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       tx_busy;
  logic [4:0] fifo_count;

  int n_checks = 0;
  int n_errors = 0;

  logic       rx_en = 1'b0;
  int         rx_ferr = 0;
  logic [7:0] rx_q [$];
  logic       seen_low;

  uart_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .CLK100MHZ  (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .Uart_TXD   (txd),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one byte for exactly one rising edge; returns on the following negedge
  task automatic write_byte(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // Entered on the first cycle of a start bit; checks both ends of every bit
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s bit%0d first", tag, k), {31'd0, txd}, {31'd0, bits[k]});
      tick(DIV - 1);
      chk($sformatf("%s bit%0d last", tag, k), {31'd0, txd}, {31'd0, bits[k]});
      tick(1);
    end
  endtask

  // Bench receiver: sample each bit mid-period
  always begin
    logic [7:0] b;
    @(negedge clk);
    if (rx_en && txd === 1'b0) begin
      repeat (DIV / 2) @(negedge clk);
      if (txd !== 1'b0) rx_ferr++;
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = txd;
      end
      repeat (DIV) @(negedge clk);
      if (txd !== 1'b1) rx_ferr++;
      rx_q.push_back(b);
    end
  end

  initial begin
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick(3);

    // Reset state, including a write offered during reset
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    tick(1);
    tx_valid = 1'b0;
    chk("reset txd", {31'd0, txd}, 32'd1);
    chk("reset busy", {31'd0, tx_busy}, 32'd0);
    chk("reset ready", {31'd0, tx_ready}, 32'd1);
    chk("reset count", {27'd0, fifo_count}, 32'd0);
    reset = 1'b0;
    tick(3);
    chk("post-reset write ignored", {27'd0, fifo_count}, 32'd0);
    chk("idle txd", {31'd0, txd}, 32'd1);

    // Single byte 0xA5 with exact two-edge latency
    write_byte(8'hA5);
    chk("lat edge N txd", {31'd0, txd}, 32'd1);
    chk("lat edge N busy", {31'd0, tx_busy}, 32'd1);
    tick(1);
    chk("lat edge N+1 txd", {31'd0, txd}, 32'd1);
    tick(1);
    check_frame(8'hA5, "A5");
    chk("A5 done busy", {31'd0, tx_busy}, 32'd0);
    chk("A5 done txd", {31'd0, txd}, 32'd1);
    tick(5);

    // Back-to-back 0x0A, 0x0D: second frame must follow with no gap
    write_byte(8'h0A);
    write_byte(8'h0D);
    chk("b2b count push+pop", {27'd0, fifo_count}, 32'd1);
    tick(1);
    check_frame(8'h0A, "0A");
    check_frame(8'h0D, "0D");
    chk("b2b done busy", {31'd0, tx_busy}, 32'd0);
    tick(5);

    // Full FIFO: 0x55 occupies the line while 17 bytes are offered
    write_byte(8'h55);
    tick(2);
    chk("full pre start", {31'd0, txd}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(i));
      chk($sformatf("full count w%0d", i), {27'd0, fifo_count}, (i < 16) ? i + 1 : 16);
      chk($sformatf("full ready w%0d", i), {31'd0, tx_ready}, (i < 15) ? 32'd1 : 32'd0);
    end
    tick(DIV * 10 - 17);
    for (int i = 0; i < 16; i++) begin
      check_frame(8'(i), $sformatf("q%0d", i));
    end
    chk("full drained count", {27'd0, fifo_count}, 32'd0);
    chk("full drained busy", {31'd0, tx_busy}, 32'd0);
    seen_low = 1'b0;
    for (int i = 0; i < 3 * DIV * 10; i++) begin
      if (txd !== 1'b1) seen_low = 1'b1;
      tick(1);
    end
    chk("0x10 dropped", {31'd0, seen_low}, 32'd0);

    // Reset during data bit 3 of 0xFF with three bytes queued
    write_byte(8'hFF);
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    tick(44);
    chk("mid bit3 count", {27'd0, fifo_count}, 32'd3);
    chk("mid bit3 busy", {31'd0, tx_busy}, 32'd1);
    reset = 1'b1;
    tick(1);
    chk("abort txd", {31'd0, txd}, 32'd1);
    chk("abort count", {27'd0, fifo_count}, 32'd0);
    chk("abort busy", {31'd0, tx_busy}, 32'd0);
    chk("abort ready", {31'd0, tx_ready}, 32'd1);
    reset = 1'b0;
    seen_low = 1'b0;
    for (int i = 0; i < 3 * DIV * 10; i++) begin
      tick(1);
      if (txd !== 1'b1) seen_low = 1'b1;
    end
    chk("no frames after abort", {31'd0, seen_low}, 32'd0);

    // Reset during a start bit must drive the line high at the next edge
    write_byte(8'h00);
    tick(1);
    tick(3);
    chk("start bit low", {31'd0, txd}, 32'd0);
    reset = 1'b1;
    tick(1);
    chk("abort start txd", {31'd0, txd}, 32'd1);
    reset = 1'b0;
    tick(5);

    // Loopback through the mid-bit receiver
    rx_en = 1'b1;
    write_byte(8'h31);
    write_byte(8'h32);
    write_byte(8'h33);
    tick(3 * DIV * 10 + 20);
    rx_en = 1'b0;
    chk("rx count", rx_q.size(), 32'd3);
    chk("rx framing", rx_ferr, 32'd0);
    chk("rx byte0", {24'd0, (rx_q.size() > 0) ? rx_q[0] : 8'hxx}, 32'h31);
    chk("rx byte1", {24'd0, (rx_q.size() > 1) ? rx_q[1] : 8'hxx}, 32'h32);
    chk("rx byte2", {24'd0, (rx_q.size() > 2) ? rx_q[2] : 8'hxx}, 32'h33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
